data_memory_unit: RTL and testbench

// Data-memory stage directly downstream of the ALU in the single-cycle MIPS datapath.

---
 rtl/data_memory_unit.sv | 158 +++++++++++++++
 tb/tb_data_memory_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_unit.sv
// data_memory_unit
//   Data-memory stage that sits right after the ALU in a single-cycle MIPS
//   datapath. The ALU result is the byte address and rt is the store data.
//   It serves lw/lh/lhu/lb/lbu/sw/sh/sb and checks alignment and range.
//   After every reset, a clear sequencer zeroes the whole array, one word per
//   clock. Accesses are ignored until that sequence has finished.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   addr         byte address (ALU result)
//   wdata        store data (rt)
//   mem_read     load this cycle
//   mem_write    store this cycle
//   size         00 byte, 01 half, 10 word, 11 reserved
//   sign_ext     1 = sign-extend byte/half loads, 0 = zero-extend
//   rdata        load result (combinational, 0 when no valid load)
//   ready        clear sequence finished, accesses accepted
//   misaligned   access not naturally aligned, or reserved size
//   out_of_range word index beyond the array
//   err_sticky   OR of all access errors since reset
module data_memory_unit #(
    parameter int DEPTH_WORDS = 256,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        misaligned,
    output logic        out_of_range,
    output logic        err_sticky
);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] clr_cnt;
    logic             ready_q;
    logic             err_q;

    // The array has no reset; the clear sequencer zeroes it instead.
    logic [31:0] mem [DEPTH_WORDS];

    logic             access;
    logic             bad;
    logic [CNT_W-1:0] widx;
    logic [31:0]      word;
    logic [3:0]       be;
    logic [31:0]      wlane;
    logic             do_store;

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sx);
        logic signed [31:0] s;
        s = 32'(signed'(b));
        return sx ? 32'(s) : {24'd0, b};
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sx);
        logic signed [31:0] s;
        s = 32'(signed'(h));
        return sx ? 32'(s) : {16'd0, h};
    endfunction

    // Nothing is accepted until ready is up.
    assign access = ready_q & (mem_read | mem_write);
    assign widx   = addr[CNT_W+1:2];
    assign word   = mem[widx];

    always_comb begin
        misaligned   = 1'b0;
        out_of_range = 1'b0;
        if (access) begin
            misaligned   = (size == 2'b01 && addr[0]) ||
                           (size == 2'b10 && addr[1:0] != 2'b00) ||
                           (size == 2'b11);
            // No wrapping: every upper address bit takes part in the check.
            out_of_range = 32'(addr[31:2]) >= 32'(DEPTH_WORDS);
        end
    end

    assign bad      = misaligned | out_of_range;
    assign do_store = access & mem_write & ~bad;

    // Read uses the pre-edge array contents, so a same-word read+write shows the old value.
    always_comb begin
        rdata = '0;
        if (access && mem_read && !bad) begin
            case (size)
                2'b10:   rdata = word;
                2'b01:   rdata = ext_half(addr[1] ? word[31:16] : word[15:0], sign_ext);
                2'b00:   rdata = ext_byte(word[8*addr[1:0] +: 8], sign_ext);
                default: rdata = '0;
            endcase
        end
    end

    // Lane enables and replicated store data (little-endian lanes).
    always_comb begin
        be    = 4'b0000;
        wlane = wdata;
        case (size)
            2'b00: begin
                be    = 4'b0001 << addr[1:0];
                wlane = {4{wdata[7:0]}};
            end
            2'b01: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (do_store) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[widx][8*k +: 8] <= wlane[8*k +: 8];
            end
        end
    end

    // Control FSM: CLEAR walks every word once, then RUN until the next reset.
    // ready is registered, so it rises one edge after the state enters RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == CNT_W'(DEPTH_WORDS - 1)) state <= ST_RUN;
                end
                ST_RUN: begin
                    ready_q <= 1'b1;
                    if (access && bad) err_q <= 1'b1;
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    assign ready      = ready_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_data_memory_unit.sv
module tb_data_memory_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] rdata;
    logic        ready;
    logic        misaligned;
    logic        out_of_range;
    logic        err_sticky;

    data_memory_unit dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata),
        .mem_read(mem_read), .mem_write(mem_write), .size(size),
        .sign_ext(sign_ext), .rdata(rdata), .ready(ready),
        .misaligned(misaligned), .out_of_range(out_of_range),
        .err_sticky(err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        mis;
        logic        oor;
    } exp_t;

    exp_t       sbq[$];
    int         total = 0;
    int         bad_cnt = 0;
    logic [7:0] mb [1024];   // byte-addressed reference memory
    logic       exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic ref_mis(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic ref_oor(input logic [31:0] a);
        return a >= 32'd1024;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sx, input logic [31:0] a);
        logic [31:0] v;
        v = '0;
        if (ref_mis(sz, a) || ref_oor(a)) return '0;
        case (sz)
            2'd2: v = {mb[a+3], mb[a+2], mb[a+1], mb[a]};
            2'd1: begin
                v = {16'd0, mb[a+1], mb[a]};
                if (sx && v[15]) v[31:16] = 16'hFFFF;
            end
            2'd0: begin
                v = {24'd0, mb[a]};
                if (sx && v[7]) v[31:8] = 24'hFFFFFF;
            end
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        if (ref_mis(sz, a) || ref_oor(a)) return;
        mb[a] = d[7:0];
        if (sz != 2'd0) mb[a+1] = d[15:8];
        if (sz == 2'd2) begin
            mb[a+2] = d[23:16];
            mb[a+3] = d[31:24];
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 1024; i++) mb[i] = 8'h00;
        exp_err = 1'b0;
    endtask

    task automatic idle();
        mem_read = 0; mem_write = 0; addr = 0; wdata = 0; size = 2'd2; sign_ext = 0;
    endtask

    // Called just after a rising edge; one access per cycle.
    task automatic access(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sx, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] got);
        exp_t e;
        exp_t p;
        e.tag   = tag;
        e.rdata = rd ? ref_load(sz, sx, a) : 32'd0;
        e.mis   = ref_mis(sz, a);
        e.oor   = ref_oor(a);
        sbq.push_back(e);
        mem_read = rd; mem_write = wr; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(negedge clk);
        p = sbq.pop_front();
        got = rdata;
        check({p.tag, "_rdata"}, rdata, p.rdata);
        check({p.tag, "_mis"}, {31'd0, misaligned}, {31'd0, p.mis});
        check({p.tag, "_oor"}, {31'd0, out_of_range}, {31'd0, p.oor});
        @(posedge clk);
        if (wr) ref_store(sz, a, wd);
        if (p.mis || p.oor) exp_err = 1'b1;
        #1;
        idle();
        check({p.tag, "_err"}, {31'd0, err_sticky}, {31'd0, exp_err});
    endtask

    // Counts rising edges until ready is seen high; a dirty store is attempted throughout.
    task automatic wait_ready(input string tag);
        int edges;
        edges = 0;
        mem_write = 1; mem_read = 1; size = 2'd2; addr = 32'd8; wdata = 32'hCAFEF00D;
        forever begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == 50) begin
                check({tag, "_clr_rdata"}, rdata, 32'd0);
                check({tag, "_clr_mis"}, {31'd0, misaligned}, 32'd0);
            end
            if (ready) break;
            if (edges > 400) break;
        end
        idle();
        check({tag, "_ready_edge"}, edges, 32'd257);
    endtask

    logic [31:0] g;

    initial begin
        idle();
        ref_reset();
        rst_n = 0;
        mem_read = 1; addr = 32'd6;
        #12;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_err", {31'd0, err_sticky}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mis", {31'd0, misaligned}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        wait_ready("init");

        access("lw0", 1, 0, 2'd2, 0, 32'd0, 0, g);      check("lw0_lit", g, 32'h0);
        access("lw1020", 1, 0, 2'd2, 0, 32'd1020, 0, g); check("lw1020_lit", g, 32'h0);
        access("lw8clr", 1, 0, 2'd2, 0, 32'd8, 0, g);    check("lw8clr_lit", g, 32'h0);
        access("sw12", 0, 1, 2'd2, 0, 32'd12, 32'hDEADBEEF, g);
        access("lw12", 1, 0, 2'd2, 0, 32'd12, 0, g);     check("lw12_lit", g, 32'hDEADBEEF);
        access("lb13", 1, 0, 2'd0, 1, 32'd13, 0, g);     check("lb13_lit", g, 32'hFFFFFFBE);
        access("lbu13", 1, 0, 2'd0, 0, 32'd13, 0, g);    check("lbu13_lit", g, 32'h000000BE);
        access("lh14", 1, 0, 2'd1, 1, 32'd14, 0, g);     check("lh14_lit", g, 32'hFFFFDEAD);
        access("sh14", 0, 1, 2'd1, 0, 32'd14, 32'h99991234, g);
        access("lw12b", 1, 0, 2'd2, 0, 32'd12, 0, g);    check("lw12b_lit", g, 32'h1234BEEF);
        access("sb12", 0, 1, 2'd0, 0, 32'd12, 32'hAAAAAA77, g);
        access("lw12c", 1, 0, 2'd2, 0, 32'd12, 0, g);    check("lw12c_lit", g, 32'h1234BE77);
        check("err_pre", {31'd0, err_sticky}, 32'd0);
        access("lw6", 1, 0, 2'd2, 0, 32'd6, 0, g);       check("lw6_lit", g, 32'h0);
        access("sw6", 0, 1, 2'd2, 0, 32'd6, 32'h01020304, g);
        access("lw4", 1, 0, 2'd2, 0, 32'd4, 0, g);       check("lw4_lit", g, 32'h0);
        access("lw8", 1, 0, 2'd2, 0, 32'd8, 0, g);       check("lw8_lit", g, 32'h0);
        access("lh_rsv", 1, 0, 2'd3, 0, 32'd0, 0, g);
        access("sw1024", 0, 1, 2'd2, 0, 32'd1024, 32'h5A5A5A5A, g);
        access("lw0b", 1, 0, 2'd2, 0, 32'd0, 0, g);      check("lw0b_lit", g, 32'h0);
        access("swhigh", 0, 1, 2'd2, 0, 32'h8000_0000, 32'h5A5A5A5A, g);
        access("lw0c", 1, 0, 2'd2, 0, 32'd0, 0, g);      check("lw0c_lit", g, 32'h0);
        // Same-word read and write: old value now, new value next cycle.
        access("rw12", 1, 1, 2'd2, 0, 32'd12, 32'h0BADF00D, g); check("rw12_lit", g, 32'h1234BE77);
        access("lw12d", 1, 0, 2'd2, 0, 32'd12, 0, g);    check("lw12d_lit", g, 32'h0BADF00D);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            logic        rd, wr;
            a  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1024, 2000)) : 32'($urandom_range(0, 63));
            if ($urandom_range(0, 4) != 0) a = a & ~32'd3;
            sz = 2'($urandom_range(0, 3));
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            access("rnd", rd, wr, sz, 1'($urandom_range(0, 1)), a, $urandom, g);
        end

        // Dirty word 8, then reset in the middle of a clear sequence.
        access("sw8", 0, 1, 2'd2, 0, 32'd8, 32'h11111111, g);
        access("lw8d", 1, 0, 2'd2, 0, 32'd8, 0, g);      check("lw8d_lit", g, 32'h11111111);
        @(negedge clk);
        rst_n = 0;
        #2;
        ref_reset();
        check("rst2_ready", {31'd0, ready}, 32'd0);
        check("rst2_err", {31'd0, err_sticky}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        repeat (100) @(posedge clk);
        #2;
        rst_n = 0;
        #2;
        check("rst3_ready", {31'd0, ready}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        wait_ready("mid");
        access("lw8e", 1, 0, 2'd2, 0, 32'd8, 0, g);      check("lw8e_lit", g, 32'h0);
        access("lw12e", 1, 0, 2'd2, 0, 32'd12, 0, g);    check("lw12e_lit", g, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=stuck exp=finish");
        $fatal(1, "timeout");
    end

endmodule
